// File: rtl/clock_pkg.sv
// Shared types and constants for the BCD timekeeping core: mode encoding,
// field limits and BCD increment helpers.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_t;

  localparam logic [7:0] SEC_MAX     = 8'h59;
  localparam logic [7:0] MIN_MAX     = 8'h59;
  localparam logic [7:0] HR_MAX_24   = 8'h23;
  localparam logic [7:0] HR_RESET_12 = 8'h12;

  // Two-digit BCD +1; the caller handles the field wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    bcd_digit_t tens;
    bcd_digit_t units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end
    return {tens, units + 4'd1};
  endfunction

  function automatic logic [7:0] next_hour12(input logic [7:0] h);
    if (h == HR_RESET_12) begin
      return 8'h01;
    end
    return bcd_inc(h);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX back to 00; carry pulses
// combinationally in the cycle whose increment causes the wrap.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  assign carry = inc && (value == MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 8'h00;
    end else if (inc) begin
      value <= (value == MAX) ? 8'h00 : bcd_inc(value);
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// Timekeeping core: 1 Hz prescaler, BCD hh:mm:ss, button-driven set mode.
// Define BCD_TIME_TWELVE_HOUR_EN for 12-hour format with a PM flag.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int PRESC_W       = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [15:0] bcd,
  output logic        colon,
  output logic        sec_tick,
  output logic [1:0]  mode,
  output logic        pm
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(TICKS_PER_SEC / 2);

  logic [1:0] btn_sync1, btn_sync2, btn_prev, btn_pulse;
  logic       mode_pulse, inc_pulse;

  // Bit 1 is the mode button, bit 0 the increment button.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync1 <= 2'b00;
      btn_sync2 <= 2'b00;
      btn_prev  <= 2'b00;
      btn_pulse <= 2'b00;
    end else begin
      btn_sync1 <= {btn_mode, btn_inc};
      btn_sync2 <= btn_sync1;
      btn_prev  <= btn_sync2;
      btn_pulse <= btn_sync2 & ~btn_prev;
    end
  end

  assign mode_pulse = btn_pulse[1];
  assign inc_pulse  = btn_pulse[0] & ~btn_pulse[1];

  mode_t              state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_d;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (mode_pulse) begin
      case (state_q)
        MODE_RUN:    state_d = MODE_SET_HR;
        MODE_SET_HR: state_d = MODE_SET_MIN;
        default:     state_d = MODE_RUN;
      endcase
    end
    if (state_q == MODE_RUN) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end else if (state_q == MODE_SET_MIN && mode_pulse) begin
      presc_d = '0;
    end
    // Registered tick is high exactly while the prescaler sits at its last count.
    tick_d = (state_d == MODE_RUN) && (presc_d == PRESC_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MODE_RUN;
      presc_q  <= '0;
      sec_tick <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      sec_tick <= tick_d;
    end
  end

  logic       sec_clr, sec_carry, min_carry, min_inc, hr_inc;
  logic [7:0] sec_val, min_val, hr_val;
  logic       unused_bits;

  assign sec_clr = rst || (state_q == MODE_SET_MIN && mode_pulse);
  assign min_inc = (state_q == MODE_RUN) ? sec_carry
                                         : (state_q == MODE_SET_MIN && inc_pulse);
  assign hr_inc  = (state_q == MODE_RUN) ? min_carry
                                         : (state_q == MODE_SET_HR && inc_pulse);

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst   (sec_clr),
    .inc   (sec_tick),
    .value (sec_val),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .value (min_val),
    .carry (min_carry)
  );

`ifdef BCD_TIME_TWELVE_HOUR_EN
  logic pm_q;

  // 12-hour sequence 12, 01 .. 11, 12; PM flips on every 11 -> 12 step.
  always_ff @(posedge clk) begin
    if (rst) begin
      hr_val <= HR_RESET_12;
      pm_q   <= 1'b0;
    end else if (hr_inc) begin
      hr_val <= next_hour12(hr_val);
      if (hr_val == 8'h11) begin
        pm_q <= ~pm_q;
      end
    end
  end

  assign pm          = pm_q;
  assign unused_bits = ^sec_val;
`else
  logic hr_carry;

  bcd_mod_counter #(.MAX(HR_MAX_24)) u_hr (
    .clk   (clk),
    .rst   (rst),
    .inc   (hr_inc),
    .value (hr_val),
    .carry (hr_carry)
  );

  assign pm          = 1'b0;
  assign unused_bits = ^{sec_val, hr_carry};
`endif

  assign bcd   = {hr_val, min_val};
  assign mode  = state_q;
  assign colon = (state_q != MODE_RUN) || (presc_q < PRESC_HALF);

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter with a 10-cycle second; also
// covers the BCD_TIME_TWELVE_HOUR_EN build when that macro is defined.
module tb_bcd_time_counter;

  localparam int T = 10;
`ifdef BCD_TIME_TWELVE_HOUR_EN
  localparam bit TWELVE = 1'b1;
`else
  localparam bit TWELVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [15:0] bcd;
  logic        colon, sec_tick, pm;
  logic [1:0]  mode;

  bcd_time_counter #(.TICKS_PER_SEC(T), .PRESC_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .bcd      (bcd),
    .colon    (colon),
    .sec_tick (sec_tick),
    .mode     (mode),
    .pm       (pm)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] bcd;
    logic [1:0]  mode;
    logic        colon;
    logic        tick;
    logic        pm;
    logic [4:0]  care;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        btn_mode;
    logic        btn_inc;
    logic        colon;
    logic        tick;
  } vec_t;

  localparam logic [4:0] C_ALL  = 5'b11111;
  localparam logic [4:0] C_NOTK = 5'b11101;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Hour field after n hour increments from the reset value.
  function automatic logic [7:0] exp_hour(input int n);
    if (TWELVE) return to_bcd((n % 12 == 0) ? 12 : n % 12);
    return to_bcd(n % 24);
  endfunction

  function automatic logic exp_pm(input int n);
    if (TWELVE) return 1'((n / 12) % 2);
    return 1'b0;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [15:0] b, input logic [1:0] m,
                               input logic c, input logic t, input logic p, input logic [4:0] care);
    exp_t e;
    e.name = name; e.bcd = b; e.mode = m; e.colon = c; e.tick = t; e.pm = p; e.care = care;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got no expectation, expected one queued");
    end else begin
      e = sb.pop_front();
      if (e.care[4]) checkVal({e.name, ".bcd"}, bcd, e.bcd);
      if (e.care[3]) checkVal({e.name, ".mode"}, mode, e.mode);
      if (e.care[2]) checkVal({e.name, ".colon"}, colon, e.colon);
      if (e.care[1]) checkVal({e.name, ".sec_tick"}, sec_tick, e.tick);
      if (e.care[0]) checkVal({e.name, ".pm"}, pm, e.pm);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // One clean low cycle, then a rising edge; returns after the edge that shows the effect.
  task automatic press(input logic m, input logic i);
    btn_mode = 1'b0; btn_inc = 1'b0;
    step(1);
    btn_mode = m; btn_inc = i;
    step(4);
    btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1);
  endtask

  task automatic addRow(input logic r, input logic c, input logic t);
    vec_t v;
    v.rst = r; v.btn_mode = 1'b0; v.btn_inc = 1'b0; v.colon = c; v.tick = t;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] h0;
    logic [7:0] h23;
    int         seen;
    h0  = exp_hour(0);
    h23 = exp_hour(23);

    // Reset, one full second of prescaler, then a reset in the middle of RUN.
    addRow(1'b1, 1'b1, 1'b0);
    addRow(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 13; k++) addRow(1'b0, (k % T) < T / 2, (k % T) == T - 1);
    addRow(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) addRow(1'b0, 1'b1, 1'b0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; btn_mode = tbl[i].btn_mode; btn_inc = tbl[i].btn_inc;
      applyStimulus($sformatf("run_row%0d", i), {h0, 8'h00}, 2'd0, tbl[i].colon, tbl[i].tick, 1'b0, C_ALL);
      step(1);
      checkOutput();
    end

    // Load hh:59 through set mode, then run into the hour rollover.
    doReset();
    step(25);
    press(1'b1, 1'b0);
    applyStimulus("enter_set_hr", {h0, 8'h00}, 2'd1, 1'b1, 1'b0, 1'b0, C_ALL);
    checkOutput();
    incs(23);
    applyStimulus("set_hr_23", {h23, 8'h00}, 2'd1, 1'b1, 1'b0, exp_pm(23), C_ALL);
    checkOutput();
    press(1'b1, 1'b0);
    incs(59);
    applyStimulus("set_min_59", {h23, 8'h59}, 2'd2, 1'b1, 1'b0, exp_pm(23), C_ALL);
    checkOutput();
    press(1'b1, 1'b0);
    applyStimulus("back_to_run", {h23, 8'h59}, 2'd0, 1'b1, 1'b0, exp_pm(23), C_ALL);
    checkOutput();
    step(580);
    applyStimulus("at_58s", {h23, 8'h59}, 2'd0, 1'b1, 1'b0, exp_pm(23), C_ALL);
    checkOutput();
    for (int j = 1; j <= 20; j++) begin
      applyStimulus($sformatf("rollover_%0d", j),
                    (j < 20) ? {h23, 8'h59} : {exp_hour(24), 8'h00}, 2'd0,
                    (j % T) < T / 2, (j % T) == T - 1, (j < 20) ? exp_pm(23) : exp_pm(24), C_ALL);
      step(1);
      checkOutput();
    end

    // Hour wrap in SET_HR, frozen seconds, held button, then minute wrap in SET_MIN.
    doReset();
    step(25);
    press(1'b1, 1'b0);
    incs(23);
    applyStimulus("hr_inc_23", {exp_hour(23), 8'h00}, 2'd1, 1'b1, 1'b0, exp_pm(23), C_ALL);
    checkOutput();
    incs(1);
    applyStimulus("hr_inc_24", {exp_hour(24), 8'h00}, 2'd1, 1'b1, 1'b0, exp_pm(24), C_ALL);
    checkOutput();
    incs(1);
    applyStimulus("hr_inc_25", {exp_hour(25), 8'h00}, 2'd1, 1'b1, 1'b0, exp_pm(25), C_ALL);
    checkOutput();
    seen = 0;
    for (int k = 0; k < 700; k++) begin
      step(1);
      if (sec_tick || !colon) seen++;
    end
    checkVal("set_hr_frozen_activity", seen, 0);
    btn_inc = 1'b1;
    step(10);
    btn_inc = 1'b0;
    step(2);
    applyStimulus("held_inc_once", {exp_hour(26), 8'h00}, 2'd1, 1'b1, 1'b0, exp_pm(26), C_ALL);
    checkOutput();
    press(1'b1, 1'b0);
    incs(59);
    applyStimulus("min_inc_59", {exp_hour(26), 8'h59}, 2'd2, 1'b1, 1'b0, 1'b0, C_NOTK);
    checkOutput();
    incs(1);
    applyStimulus("min_inc_60", {exp_hour(26), 8'h00}, 2'd2, 1'b1, 1'b0, 1'b0, C_NOTK);
    checkOutput();
    incs(1);
    applyStimulus("min_inc_61", {exp_hour(26), 8'h01}, 2'd2, 1'b1, 1'b0, 1'b0, C_NOTK);
    checkOutput();
    press(1'b1, 1'b0);
    applyStimulus("run_restart", {exp_hour(26), 8'h01}, 2'd0, 1'b1, 1'b0, 1'b0, C_NOTK);
    checkOutput();
    step(T - 1);
    applyStimulus("first_tick", {exp_hour(26), 8'h01}, 2'd0, 1'b0, 1'b1, 1'b0, C_NOTK);
    checkOutput();
    step(1);
    applyStimulus("after_first_tick", {exp_hour(26), 8'h01}, 2'd0, 1'b1, 1'b0, 1'b0, C_NOTK);
    checkOutput();

    // Simultaneous mode and inc: mode advances, inc is dropped.
    doReset();
    press(1'b1, 1'b1);
    applyStimulus("both_in_run", {h0, 8'h00}, 2'd1, 1'b1, 1'b0, 1'b0, C_ALL);
    checkOutput();
    press(1'b1, 1'b1);
    applyStimulus("both_in_set_hr", {h0, 8'h00}, 2'd2, 1'b1, 1'b0, 1'b0, C_ALL);
    checkOutput();
    press(1'b1, 1'b1);
    applyStimulus("both_in_set_min", {h0, 8'h00}, 2'd0, 1'b1, 1'b0, 1'b0, C_ALL);
    checkOutput();

    // Reset in SET_MIN with a frozen nonzero prescaler and a mode pulse in flight.
    doReset();
    step(13);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    incs(3);
    applyStimulus("pre_reset", {h0, 8'h03}, 2'd2, 1'b1, 1'b0, 1'b0, C_ALL);
    checkOutput();
    btn_mode = 1'b1;
    step(3);
    rst = 1'b1;
    btn_mode = 1'b0;
    step(1);
    rst = 1'b0;
    applyStimulus("mid_set_reset", {h0, 8'h00}, 2'd0, 1'b1, 1'b0, 1'b0, C_ALL);
    checkOutput();
    step(4);
    applyStimulus("pulse_dropped", {h0, 8'h00}, 2'd0, 1'b1, 1'b0, 1'b0, C_ALL);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
